// File: rtl/regfile_mp.sv
// Multi-port register file: two byte-enabled write ports (B over A on overlap),
// two combinational read ports, optional hardwired r0 and write-to-read bypass.
module regfile_mp #(
   parameter int DW      = 32,
   parameter int AW      = 5,
   parameter int ZERO_R0 = 1,
   parameter int BYPASS  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             we_a,
   input  logic [AW-1:0]    waddr_a,
   input  logic [DW-1:0]    wdata_a,
   input  logic [DW/8-1:0]  wbe_a,
   input  logic             we_b,
   input  logic [AW-1:0]    waddr_b,
   input  logic [DW-1:0]    wdata_b,
   input  logic [DW/8-1:0]  wbe_b,
   input  logic [AW-1:0]    raddr1,
   input  logic [AW-1:0]    raddr2,
   output logic [DW-1:0]    rdata1,
   output logic [DW-1:0]    rdata2
);

   localparam int NB    = DW / 8;
   localparam int DEPTH = 1 << AW;

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];

   // Per-lane resolution of one register: port B lane, else port A lane, else old lane.
   function automatic logic [DW-1:0] lane_mux(
      input logic [DW-1:0] old_v,
      input logic          hit_a,
      input logic [DW-1:0] wd_a,
      input logic [NB-1:0] be_a,
      input logic          hit_b,
      input logic [DW-1:0] wd_b,
      input logic [NB-1:0] be_b
   );
      logic [DW-1:0] r;
      r = old_v;
      for (int k = 0; k < NB; k++) begin
         if (hit_b && be_b[k]) begin
            r[8*k +: 8] = wd_b[8*k +: 8];
         end else if (hit_a && be_a[k]) begin
            r[8*k +: 8] = wd_a[8*k +: 8];
         end else begin
            r[8*k +: 8] = old_v[8*k +: 8];
         end
      end
      return r;
   endfunction

   // Read-port value: hardwired zero, bypassed next value, or stored value.
   function automatic logic [DW-1:0] read_port(input logic [AW-1:0] ra);
      logic [DW-1:0] r;
      if ((ZERO_R0 != 0) && (ra == '0)) begin
         r = '0;
      end else if ((BYPASS != 0) && rst) begin
         r = lane_mux(mem_q[ra], we_a && (waddr_a == ra), wdata_a, wbe_a,
                      we_b && (waddr_b == ra), wdata_b, wbe_b);
      end else begin
         r = mem_q[ra];
      end
      return r;
   endfunction

   // Next-state for every register: clear wins, r0 optionally pinned, else write merge.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         if (clr) begin
            mem_d[i] = '0;
         end else if ((ZERO_R0 != 0) && (i == 0)) begin
            mem_d[i] = '0;
         end else begin
            mem_d[i] = lane_mux(mem_q[i], we_a && (waddr_a == AW'(i)), wdata_a, wbe_a,
                                we_b && (waddr_b == AW'(i)), wdata_b, wbe_b);
         end
      end
   end

   // Storage flops with asynchronous clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   // Combinational read ports.
   always_comb begin
      rdata1 = read_port(raddr1);
      rdata2 = read_port(raddr2);
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench: two regfile_mp builds (bypass+r0 zero, and neither) checked
// every cycle against an array model, plus directed literal checks.
module tb_regfile_mp;

   logic        clk;
   logic        rst;
   logic        clr;
   logic        we_a, we_b;
   logic [4:0]  waddr_a, waddr_b;
   logic [31:0] wdata_a, wdata_b;
   logic [3:0]  wbe_a, wbe_b;
   logic [4:0]  raddr1, raddr2;
   logic [31:0] rd1_0, rd2_0, rd1_1, rd2_1;

   int nchk = 0;
   int nerr = 0;
   logic chk_en = 1'b0;

   // inst 0: BYPASS=1, ZERO_R0=1 ; inst 1: BYPASS=0, ZERO_R0=0
   logic [31:0] mdl [2][32];

   regfile_mp u_dut0 (
      .clk(clk), .rst(rst), .clr(clr),
      .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a), .wbe_a(wbe_a),
      .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b), .wbe_b(wbe_b),
      .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_0), .rdata2(rd2_0)
   );

   regfile_mp #(.BYPASS(0), .ZERO_R0(0)) u_dut1 (
      .clk(clk), .rst(rst), .clr(clr),
      .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a), .wbe_a(wbe_a),
      .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b), .wbe_b(wbe_b),
      .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_1), .rdata2(rd2_1)
   );

   initial begin
      clk = 1'b1;
      forever #5 clk = ~clk;
   end

   // Value register a holds after this edge's writes (clr and r0 handled by caller).
   function automatic logic [31:0] written(int inst, logic [4:0] a);
      logic [31:0] v;
      v = mdl[inst][a];
      for (int k = 0; k < 4; k++) begin
         if (we_b && waddr_b == a && wbe_b[k]) v[8*k +: 8] = wdata_b[8*k +: 8];
         else if (we_a && waddr_a == a && wbe_a[k]) v[8*k +: 8] = wdata_a[8*k +: 8];
      end
      return v;
   endfunction

   function automatic logic [31:0] exp_next(int inst, logic [4:0] a);
      if (clr) return 32'h0;
      if (inst == 0 && a == 5'd0) return 32'h0;
      return written(inst, a);
   endfunction

   function automatic logic [31:0] exp_read(int inst, logic [4:0] a);
      if (!rst) return 32'h0;
      if (inst == 0 && a == 5'd0) return 32'h0;
      if (inst == 0) return written(inst, a);
      return mdl[inst][a];
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int n = 0; n < 2; n++)
            for (int i = 0; i < 32; i++) mdl[n][i] <= 32'h0;
      end else begin
         for (int n = 0; n < 2; n++)
            for (int i = 0; i < 32; i++) mdl[n][i] <= exp_next(n, 5'(i));
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   always @(posedge clk) begin
      #3;
      if (chk_en) begin
         chk("rd1_byp", rd1_0, exp_read(0, raddr1));
         chk("rd2_byp", rd2_0, exp_read(0, raddr2));
         chk("rd1_nobyp", rd1_1, exp_read(1, raddr1));
         chk("rd2_nobyp", rd2_1, exp_read(1, raddr2));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we_a = 1'b0; we_b = 1'b0; clr = 1'b0;
   endtask

   task automatic wr_a(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
      we_a = 1'b1; waddr_a = a; wdata_a = d; wbe_a = be;
      tick();
      we_a = 1'b0;
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0;
      we_a = 1'b1; waddr_a = 5'd3; wdata_a = 32'hFFFFFFFF; wbe_a = 4'hF;
      we_b = 1'b0; waddr_b = 5'd0; wdata_b = 32'h0; wbe_b = 4'h0;
      raddr1 = 5'd3; raddr2 = 5'd0;
      #5 rst = 1'b0;
      #2 chk_en = 1'b1;
      #1 chk("rst_low_r3", rd1_0, 32'h0);
      chk("rst_low_r3_nb", rd1_1, 32'h0);
      #17 rst = 1'b1;
      tick();
      we_a = 1'b0;
      #2 chk("rst_first_wr", rd1_0, 32'hFFFFFFFF);
      chk("rst_first_wr_nb", rd1_1, 32'hFFFFFFFF);
      for (int a = 0; a < 32; a++) begin
         raddr1 = 5'(a); raddr2 = 5'(31 - a);
         tick();
      end

      // fill and readback
      for (int i = 0; i < 32; i++) wr_a(5'(i), 32'(32'h01010101 * i), 4'hF);
      raddr1 = 5'd0; raddr2 = 5'd21;
      #2 chk("fill_r0", rd1_0, 32'h0);
      chk("fill_r21", rd2_0, 32'h15151515);
      tick();
      raddr1 = 5'd10;
      #2 chk("fill_r10", rd1_0, 32'h0A0A0A0A);

      // byte enables
      tick();
      wr_a(5'd5, 32'h11223344, 4'hF);
      wr_a(5'd5, 32'hAABBCCDD, 4'b0101);
      raddr1 = 5'd5;
      #2 chk("be_r5", rd1_0, 32'h11BB33DD);
      chk("be_r5_nb", rd1_1, 32'h11BB33DD);

      // collision and dual distinct writes
      tick();
      wr_a(5'd7, 32'h0, 4'hF);
      we_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'hAAAAAAAA; wbe_a = 4'hF;
      we_b = 1'b1; waddr_b = 5'd7; wdata_b = 32'hBBBBBBBB; wbe_b = 4'b0011;
      tick();
      idle(); raddr1 = 5'd7;
      #2 chk("coll_r7", rd1_0, 32'hAAAABBBB);
      chk("coll_r7_nb", rd1_1, 32'hAAAABBBB);
      tick();
      we_a = 1'b1; waddr_a = 5'd8; wdata_a = 32'h88888888; wbe_a = 4'hF;
      we_b = 1'b1; waddr_b = 5'd9; wdata_b = 32'h99999999; wbe_b = 4'hF;
      tick();
      idle(); raddr1 = 5'd8; raddr2 = 5'd9;
      #2 chk("dual_r8", rd1_1, 32'h88888888);
      chk("dual_r9", rd2_1, 32'h99999999);

      // bypass vs no bypass
      tick();
      wr_a(5'd12, 32'h12345678, 4'hF);
      raddr1 = 5'd12;
      we_b = 1'b1; waddr_b = 5'd12; wdata_b = 32'hCAFEF00D; wbe_b = 4'hF;
      #2 chk("byp_same_cyc", rd1_0, 32'hCAFEF00D);
      chk("nobyp_same_cyc", rd1_1, 32'h12345678);
      tick();
      idle();
      #2 chk("byp_after", rd1_0, 32'hCAFEF00D);
      chk("nobyp_after", rd1_1, 32'hCAFEF00D);

      // hardwired r0
      tick();
      we_a = 1'b1; waddr_a = 5'd0; wdata_a = 32'hDEADBEEF; wbe_a = 4'hF; raddr1 = 5'd0;
      #2 chk("r0_byp_zero", rd1_0, 32'h0);
      tick();
      idle();
      #2 chk("r0_zero", rd1_0, 32'h0);
      chk("r0_plain", rd1_1, 32'hDEADBEEF);

      // synchronous clear with a concurrent write
      tick();
      clr = 1'b1; we_a = 1'b1; waddr_a = 5'd4; wdata_a = 32'h55555555; wbe_a = 4'hF;
      raddr1 = 5'd4; raddr2 = 5'd21;
      #2 chk("clr_not_byp", rd1_0, 32'h55555555);
      chk("clr_stored", rd2_1, 32'h15151515);
      tick();
      idle();
      #2 chk("clr_r4", rd1_0, 32'h0);
      chk("clr_r4_nb", rd1_1, 32'h0);
      chk("clr_r21", rd2_1, 32'h0);
      for (int a = 0; a < 32; a++) begin
         raddr1 = 5'(a); raddr2 = 5'(a ^ 1);
         tick();
      end

      // randomized traffic, concentrated on a few addresses to force collisions
      for (int c = 0; c < 400; c++) begin
         we_a = 1'($urandom_range(0, 1));
         we_b = 1'($urandom_range(0, 1));
         waddr_a = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
         waddr_b = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
         wdata_a = $urandom; wdata_b = $urandom;
         wbe_a = 4'($urandom); wbe_b = 4'($urandom);
         raddr1 = ($urandom_range(0, 1) == 0) ? waddr_a : 5'($urandom_range(0, 5));
         raddr2 = ($urandom_range(0, 1) == 0) ? waddr_b : 5'($urandom);
         clr = ($urandom_range(0, 39) == 0);
         if (c == 200) rst = 1'b0;
         if (c == 202) rst = 1'b1;
         tick();
      end
      idle();
      tick();

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file: generalised data width and depth, two write ports with byte enables and a fixed priority, optional hardwired-zero register 0, optional write-to-read bypass, and a single-cycle synchronous clear. It replaces the fixed 32x32 single-write register file as the operand store of the CPU datapath, feeding both ALU operand buses and accepting write-backs from the execute and load paths in the same cycle.

## Interface
- DW, 32, data width in bits; must be a multiple of 8
- AW, 5, address width; depth = 2**AW registers
- ZERO_R0, 1, 1: register 0 always reads 0 and ignores writes; 0: register 0 is an ordinary register
- BYPASS, 1, 1: a read of an address written this cycle returns the new data; 0: reads return the stored value only
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset; clears every register to 0
- clr  in  1  synchronous clear; clears every register to 0 at the next rising edge
- we_a  in  1  write enable, port A (execute write-back)
- waddr_a  in  AW  write address, port A
- wdata_a  in  DW  write data, port A
- wbe_a  in  DW/8  byte enables, port A; bit k covers wdata_a[8k+7:8k]
- we_b  in  1  write enable, port B (load write-back)
- waddr_b  in  AW  write address, port B
- wdata_b  in  DW  write data, port B
- wbe_b  in  DW/8  byte enables, port B
- raddr1  in  AW  read address, port 1
- raddr2  in  AW  read address, port 2
- rdata1  out  DW  read data, port 1 (combinational)
- rdata2  out  DW  read data, port 2 (combinational)

## Operation
- Storage: 2**AW registers of DW bits.
- Write: on rising clk with rst high and clr low, for each port with we=1, every byte k with wbe[k]=1 is loaded from wdata; bytes with wbe[k]=0 keep their value. we=1 with wbe all 0 is a no-op.
- Same-address collision (we_a=we_b=1, waddr_a=waddr_b): per byte, port B wins where wbe_b[k]=1; port A's byte is written where wbe_b[k]=0 and wbe_a[k]=1.
- Different addresses: both writes take effect in the same edge.
- clr=1: all registers become 0 at the edge; all writes in that cycle are discarded.
- ZERO_R0=1: writes to address 0 are discarded; reads of address 0 return 0 regardless of BYPASS.
- Read, BYPASS=0: rdataN = register[raddrN].
- Read, BYPASS=1: rdataN is the value the register will hold after the current edge's write, built per byte: port B byte if we_b, waddr_b=raddrN and wbe_b[k]; else port A byte if we_a, waddr_a=raddrN and wbe_a[k]; else stored byte. clr is not bypassed (reads during clr show stored or bypassed data, not 0).
- Both read ports are independent; raddr1=raddr2 returns identical data.

## Timing
- Reset: rst low clears all registers immediately, independent of clk; rdata1/rdata2 read 0 for all addresses while rst is low and after release until written. Writes presented while rst is low are lost. rst deasserting mid-write-burst: the first edge with rst high performs that cycle's write.
- Write latency: 1 edge; with BYPASS=0, new data visible on rdataN after the edge; with BYPASS=1, visible combinationally in the same cycle and held after the edge.
- Read latency: 0 cycles (combinational from raddr, stored state, and write inputs when BYPASS=1).
- No handshake; every write with we=1 is accepted every cycle, no stalls.
- Address wrap: none; all AW-bit addresses valid.

## Test plan
- Reset: drive rst low at t=5 ns with we_a=1, waddr_a=3, wdata_a=32'hFFFFFFFF, release at t=25 ns -> rdata1 at raddr1=3 is 0 before first active edge, 32'hFFFFFFFF after it; all other addresses read 0.
- Fill and readback: write register i = 32'h01010101*i for i=0..31 via port A, wbe_a=4'hF -> with ZERO_R0=1, raddr1=0 reads 0, raddr2=21 reads 32'h15151515, raddr1=10 reads 32'h0A0A0A0A.
- Byte enables: reg 5 = 32'h11223344; write port A wdata_a=32'hAABBCCDD, wbe_a=4'b0101 -> reg 5 reads 32'h11BB33DD.
- Collision: reg 7 = 0; same edge port A 32'hAAAAAAAA wbe 4'hF and port B 32'hBBBBBBBB wbe 4'b0011, both to 7 -> reg 7 reads 32'hAAAABBBB; different addresses 8/9 in same edge both land.
- Bypass: BYPASS=1, reg 12 = 32'h12345678, raddr1=12, port B writes 32'hCAFEF00D wbe 4'hF to 12 -> rdata1=32'hCAFEF00D before the edge; rebuild with BYPASS=0 -> rdata1=32'h12345678 until after the edge.
- Clear: registers filled, assert clr for one cycle with we_a=1 to reg 4 -> after edge every address reads 0, including 4.
